// File: rtl/spi_dac_writer.sv
// SPI master: serialises one {CMD, chan, data} 24-bit write-and-update frame per handshake.
// Latency: handshake edge E0 -> cs_n low after E0; last sclk rise (DAC update) at E47.
// Backpressure: in_ready is high only in IDLE; samples offered during SHIFT/GAP are held off.
//
// Ports:
//   clk16     16 MHz clock, all logic on its rising edge
//   rst       asynchronous active-high reset (aborts any frame in progress)
//   in_valid / in_ready / in_chan / in_data   upstream sample handshake
//   sclk / mosi / cs_n                        SPI mode 0 pins, SCLK = clk16/2
//   busy      high whenever a frame or the post-frame gap is in progress
module spi_dac_writer #(
  parameter logic [3:0] CMD            = 4'b0011,
  parameter int         CS_HIGH_CYCLES = 4
) (
  input  logic        clk16,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_chan,
  input  logic [15:0] in_data,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(CS_HIGH_CYCLES - 1);

  state_t      state;
  // Frame bit 23 goes straight onto mosi at the handshake, so the register
  // only needs to hold the remaining 23 bits.
  logic [22:0] shreg;
  logic [4:0]  bit_cnt;
  logic [3:0]  gap_cnt;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk16 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg   <= {CMD[2:0], in_chan, in_data};
            mosi    <= CMD[3];
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (!sclk) begin
            sclk <= 1'b1;
          end else begin
            // Data changes only on the falling sclk edge: half an SCLK
            // period of setup and hold around every rising edge.
            sclk <= 1'b0;
            if (bit_cnt != 5'd23) begin
              bit_cnt <= bit_cnt + 5'd1;
              mosi    <= shreg[22];
              shreg   <= {shreg[21:0], 1'b0};
            end else begin
              cs_n    <= 1'b1;
              mosi    <= 1'b0;
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end

        GAP: begin
          gap_cnt <= gap_cnt + 4'd1;
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
